sc_memacc: RTL and testbench

SC_MEMACC -- requirements
Module: sc_memacc

---
 rtl/sc_pkg.sv | 17 +
 rtl/sc_memacc_timer.sv | 28 ++
 rtl/sc_memacc.sv | 102 ++++++++++
 tb/tb_sc_memacc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared constants for the sc_memacc memory-access slice: FSM encoding,
// wait-counter width and the latched command record.
package sc_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/sc_memacc_timer.sv
// Wait counter for the ACCESS phase: counts enabled cycles and flags the
// cycle in which the count reaches the programmed limit.
module sc_memacc_timer
  import sc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  // count_reg holds the number of completed cycles, so the limit-th cycle
  // is the one where count_reg + 1 equals the limit.
  assign expired = enable && (CNT_W'(count_reg + 1'b1) == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sc_memacc.sv
// Single-request memory access sequencer (IDLE -> ACCESS -> DONE) with ack
// timeout. Optional alignment check enabled by SC_MEMACC_ALIGN_CHECK_EN.
module sc_memacc
  import sc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  logic [1:0]       state_reg, state_next;
  mem_cmd_t         cmd_reg;
  logic             mem_req_reg;
  logic             done_reg, err_reg;
  logic [31:0]      rdata_reg;
  logic             accept, misaligned, ack_hit, launch, timer_expired;
  logic [CNT_W-1:0] limit;

  assign limit = CNT_W'(ACK_TIMEOUT);

`ifdef SC_MEMACC_ALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign accept  = (state_reg == ST_IDLE) && start;
  assign launch  = accept && !misaligned;
  assign ack_hit = (state_reg == ST_ACCESS) && mem_ack;

  sc_memacc_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .enable  (state_reg == ST_ACCESS),
    .limit   (limit),
    .expired (timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = misaligned ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (mem_ack || timer_expired) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cmd_reg     <= '0;
      mem_req_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= (state_next == ST_ACCESS);
      done_reg    <= (state_next == ST_DONE);
      // Ack wins over a timeout landing on the same edge.
      err_reg     <= (accept && misaligned) ||
                     ((state_reg == ST_ACCESS) && !mem_ack && timer_expired);
      if (launch) begin
        cmd_reg.we    <= we;
        cmd_reg.addr  <= addr;
        cmd_reg.wdata <= wdata;
      end else if (state_next != ST_ACCESS) begin
        cmd_reg <= '0;
      end
      if (ack_hit && !cmd_reg.we) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = cmd_reg.we;
  assign mem_addr  = cmd_reg.addr;
  assign mem_wdata = cmd_reg.wdata;

endmodule

// File: tb/tb_sc_memacc.sv
// Scoreboard bench for sc_memacc: the driver queues the expected completion
// of each access, a negedge monitor checks it whenever done is seen.
module tb_sc_memacc;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst, start, we, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  sc_memacc #(.ACK_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_err", {31'd0, err}, {31'd0, e.err});
        check("done_rdata", rdata, e.rdata);
        $display("[TB] completion err=%0b rdata=0x%08h (expected err=%0b rdata=0x%08h)",
                 err, rdata, e.err, e.rdata);
      end
    end
  end

  // ack_cyc: ACCESS cycle (1-based) carrying mem_ack, 0 = never.
  // noise: keep start/mem_ack asserted where they must be ignored.
  task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int ack_cyc,
                         input logic [31:0] rd, input bit noise);
    int   acc;
    bit   acked;
    exp_t e;
    acked = (ack_cyc >= 1) && (ack_cyc <= TMO);
    acc   = acked ? ack_cyc : TMO;
    if (!w && acked) model_rdata = rd;
    e.err   = !acked;
    e.rdata = model_rdata;
    exp_q.push_back(e);
    $display("[TB] issue %s we=%0b addr=0x%08h wdata=0x%08h ack_cyc=%0d",
             tag, w, a, d, ack_cyc);

    @(posedge clk); #1;
    start = 1'b1; we = w; addr = a; wdata = d;
    mem_ack = noise; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);

    for (int k = 1; k <= acc; k++) begin
      @(posedge clk); #1;
      if (noise) begin
        start = 1'b1; we = ~w; addr = 32'hFFFF_FFF0; wdata = 32'h0;
      end else begin
        start = 1'b0;
      end
      mem_ack   = (k == ack_cyc);
      mem_rdata = (k == ack_cyc) ? rd : 32'hBAD0BAD0;
      @(negedge clk);
      check({tag, "_acc_req"},   {31'd0, mem_req}, 32'd1);
      check({tag, "_acc_we"},    {31'd0, mem_we},  {31'd0, w});
      check({tag, "_acc_addr"},  mem_addr,  a);
      check({tag, "_acc_wdata"}, mem_wdata, d);
      check({tag, "_acc_done"},  {31'd0, done},    32'd0);
    end

    @(posedge clk); #1;
    start = noise; mem_ack = noise; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done},    32'd1);
    check({tag, "_done_req"},   {31'd0, mem_req}, 32'd0);
    check({tag, "_done_addr"},  mem_addr,         32'd0);
    check({tag, "_done_busy"},  {31'd0, busy},    32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h55;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    model_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_err",     {31'd0, err},     32'd0);
    check("rst_req",     {31'd0, mem_req}, 32'd0);
    check("rst_we",      {31'd0, mem_we},  32'd0);
    check("rst_addr",    mem_addr,         32'd0);
    check("rst_wdata",   mem_wdata,        32'd0);
    check("rst_rdata",   rdata,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0;

    run_txn("load",      1'b0, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF, 1'b0);
    run_txn("store",     1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hBAD0BAD0, 1'b0);
    run_txn("timeout",   1'b0, 32'h0000_0030, 32'h0,         0, 32'h0,        1'b0);
    run_txn("ack_tmo",   1'b0, 32'h0000_0034, 32'h0,       TMO, 32'hCAFE_F00D, 1'b0);
    run_txn("noisy_st",  1'b1, 32'h0000_0044, 32'hAABB_CCDD, 2, 32'hBAD0BAD0, 1'b1);

`ifdef SC_MEMACC_ALIGN_CHECK_EN
    begin
      exp_t e;
      e.err = 1'b1; e.rdata = model_rdata;
      exp_q.push_back(e);
      $display("[TB] issue misaligned addr=0x00000013");
      @(posedge clk); #1;
      start = 1'b1; we = 1'b0; addr = 32'h0000_0013; mem_ack = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("misal_done", {31'd0, done},    32'd1);
      check("misal_req",  {31'd0, mem_req}, 32'd0);
    end
`else
    run_txn("unaligned", 1'b0, 32'h0000_0013, 32'h0,         1, 32'h1357_2468, 1'b0);
`endif

    // Reset landing in the second ACCESS cycle aborts with no done pulse.
    $display("[TB] issue reset_abort addr=0x00000040");
    @(posedge clk); #1;
    start = 1'b1; we = 1'b0; addr = 32'h0000_0040; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_before", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = 32'd0;
    @(negedge clk);
    check("abort_req",   {31'd0, mem_req}, 32'd0);
    check("abort_busy",  {31'd0, busy},    32'd0);
    check("abort_done",  {31'd0, done},    32'd0);
    check("abort_rdata", rdata,            32'd0);

    run_txn("post_rst",  1'b0, 32'h0000_0050, 32'h0,         2, 32'h0BAD_F00D, 1'b0);

    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_busy",    {31'd0, busy}, 32'd0);
    check("final_pending", exp_q.size(),  32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
